// File: rtl/spi_pkg.sv
// Shared types and helpers for the FIFO-based SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StXfer,
    StHold,
    StGap
  } spi_state_e;

  localparam logic [1:0] LEN_8  = 2'd0;
  localparam logic [1:0] LEN_16 = 2'd1;
  localparam logic [1:0] LEN_24 = 2'd2;
  localparam logic [1:0] LEN_32 = 2'd3;

  // Word length in bits for a ctrl_len encoding.
  function automatic logic [5:0] len_bits(input logic [1:0] len);
    case (len)
      LEN_8:   return 6'd8;
      LEN_16:  return 6'd16;
      LEN_24:  return 6'd24;
      LEN_32:  return 6'd32;
      default: return 6'd32;
    endcase
  endfunction

  // Word bit index of the pos-th bit on the wire.
  function automatic logic [4:0] bit_idx(input logic lsb, input logic [5:0] n,
                                         input logic [4:0] pos);
    logic [5:0] msb_idx;
    msb_idx = n - 6'd1 - {1'b0, pos};
    return lsb ? pos : msb_idx[4:0];
  endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head is zero while empty.
module spi_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_cpu,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  // A pop frees the slot in the same cycle, so push at full is accepted with a pop.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem_q[rptr_q[AW-1:0]];

  // Pointer update.
  always_ff @(posedge clk_cpu or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge clk_cpu) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/spi_master_fifo.sv
// SPI master with TX/RX FIFOs, all CPOL/CPHA modes, bit order and word length selection.
module spi_master_fifo
  import spi_pkg::*;
#(
  parameter int unsigned NUM_SS     = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 16,
  localparam int unsigned SsW       = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk_cpu,
  input  logic              rst,
  input  logic [DIV_W-1:0]  spi_bitrate,
  input  logic              ctrl_en,
  input  logic              ctrl_cpol,
  input  logic              ctrl_cpha,
  input  logic              ctrl_lsb,
  input  logic [1:0]        ctrl_len,
  input  logic [SsW-1:0]    ctrl_ss_sel,
  input  logic [31:0]       tx_data,
  input  logic              tx_push,
  output logic              tx_full,
  output logic [31:0]       rx_data,
  input  logic              rx_pop,
  output logic              rx_empty,
  input  logic              irq_en,
  output logic              IRQ_SPI,
  output logic              rx_ovf,
  output logic              busy,
  output logic              SCK,
  output logic              MOSI,
  input  logic              MISO,
  output logic [NUM_SS-1:0] SS
);

  spi_state_e        state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, half_m1;
  logic              tick, abort, tx_pop, rx_push;
  logic              tx_empty, rx_full;
  logic [31:0]       tx_head;
  logic [5:0]        edge_q, n_bits, nxt_bit;
  logic [4:0]        pos;
  logic              edge_last, sample;
  logic              cpol_q, cpha_q, lsb_q;
  logic [1:0]        len_q;
  logic [31:0]       tx_word_q, rx_word_q;
  logic              sck_q, mosi_q, ovf_q;
  logic [NUM_SS-1:0] ss_q, ss_dec;

  spi_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_cpu (clk_cpu),
    .rst     (rst),
    .push    (tx_push),
    .wdata   (tx_data),
    .pop     (tx_pop),
    .rdata   (tx_head),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  spi_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_cpu (clk_cpu),
    .rst     (rst),
    .push    (rx_push),
    .wdata   (rx_word_q),
    .pop     (rx_pop),
    .rdata   (rx_data),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  // Half-period divisor, 0 behaves as 1.
  assign half_m1 = (spi_bitrate == '0) ? '0 : spi_bitrate - DIV_W'(1);
  assign tick    = (state_q != StIdle) && (cnt_q == half_m1);
  assign abort   = (state_q != StIdle) && !ctrl_en;

  // Edge bookkeeping: edge_q counts completed SCK edges, two per bit.
  assign n_bits    = len_bits(len_q);
  assign pos       = edge_q[5:1];
  assign edge_last = ({1'b0, edge_q} == ({n_bits, 1'b0} - 7'd1));
  // Leading edges are even edge_q values; CPHA flips which edge samples.
  assign sample    = ~edge_q[0] ^ cpha_q;
  assign nxt_bit   = cpha_q ? {1'b0, pos} : {1'b0, pos} + 6'd1;

  // One-hot active-low slave select for the requested slave.
  always_comb begin
    ss_dec = '1;
    for (int unsigned i = 0; i < NUM_SS; i++) begin
      if (ctrl_ss_sel == SsW'(i)) ss_dec[i] = 1'b0;
    end
  end

  // Next-state and FIFO strobes.
  always_comb begin
    state_d = state_q;
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    if (abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (ctrl_en && !tx_empty) begin
            tx_pop  = 1'b1;
            state_d = StSetup;
          end
        end
        StSetup: if (tick) state_d = StXfer;
        StXfer:  if (tick && edge_last) state_d = StHold;
        StHold: begin
          if (tick) begin
            rx_push = 1'b1;
            state_d = StGap;
          end
        end
        StGap:   if (tick) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_cpu or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Tick counter: idle at zero, restarts on every state entry and every tick.
  always_ff @(posedge clk_cpu or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (state_q == StIdle || tick || state_d != state_q) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

  // Serial datapath: SCK, MOSI, SS, shift words and overflow pulse.
  always_ff @(posedge clk_cpu or negedge rst) begin
    if (!rst) begin
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      ss_q      <= '1;
      ovf_q     <= 1'b0;
      edge_q    <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      len_q     <= LEN_8;
      tx_word_q <= '0;
      rx_word_q <= '0;
    end else begin
      ovf_q <= rx_push & rx_full & ~rx_pop;
      if (abort) begin
        sck_q <= ctrl_cpol;
        ss_q  <= '1;
      end else begin
        case (state_q)
          StIdle: begin
            sck_q <= ctrl_cpol;
            ss_q  <= '1;
            if (tx_pop) begin
              cpol_q    <= ctrl_cpol;
              cpha_q    <= ctrl_cpha;
              lsb_q     <= ctrl_lsb;
              len_q     <= ctrl_len;
              tx_word_q <= tx_head;
              rx_word_q <= '0;
              edge_q    <= '0;
              ss_q      <= ss_dec;
              mosi_q    <= tx_head[bit_idx(ctrl_lsb, len_bits(ctrl_len), 5'd0)];
            end
          end
          StXfer: begin
            if (tick) begin
              sck_q  <= ~sck_q;
              edge_q <= edge_q + 6'd1;
              if (sample) begin
                rx_word_q[bit_idx(lsb_q, n_bits, pos)] <= MISO;
              end else if (nxt_bit < n_bits) begin
                mosi_q <= tx_word_q[bit_idx(lsb_q, n_bits, nxt_bit[4:0])];
              end
            end
          end
          StHold: begin
            sck_q <= cpol_q;
            if (tick) ss_q <= '1;
          end
          default: ;
        endcase
      end
    end
  end

  assign SCK     = sck_q;
  assign MOSI    = mosi_q;
  assign SS      = ss_q;
  assign rx_ovf  = ovf_q;
  assign busy    = (state_q != StIdle);
  assign IRQ_SPI = irq_en & ~rx_empty;

endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed and randomized bench for spi_master_fifo with an SPI slave model.
module tb_spi_master_fifo;

  logic        clk_cpu = 1'b0;
  logic        rst;
  logic [15:0] spi_bitrate;
  logic        ctrl_en, ctrl_cpol, ctrl_cpha, ctrl_lsb;
  logic [1:0]  ctrl_len, ctrl_ss_sel;
  logic [31:0] tx_data, rx_data;
  logic        tx_push, tx_full, rx_pop, rx_empty, irq_en, IRQ_SPI, rx_ovf, busy;
  logic        SCK, MOSI, MISO;
  logic [3:0]  SS;

  logic loopback = 1'b0;
  logic slave_miso = 1'b0;
  logic ss_low;

  always #5 clk_cpu = ~clk_cpu;

  assign MISO   = loopback ? MOSI : slave_miso;
  assign ss_low = (SS != 4'hF);

  spi_master_fifo #(
    .NUM_SS     (4),
    .FIFO_DEPTH (4),
    .DIV_W      (16)
  ) dut (
    .clk_cpu     (clk_cpu),
    .rst         (rst),
    .spi_bitrate (spi_bitrate),
    .ctrl_en     (ctrl_en),
    .ctrl_cpol   (ctrl_cpol),
    .ctrl_cpha   (ctrl_cpha),
    .ctrl_lsb    (ctrl_lsb),
    .ctrl_len    (ctrl_len),
    .ctrl_ss_sel (ctrl_ss_sel),
    .tx_data     (tx_data),
    .tx_push     (tx_push),
    .tx_full     (tx_full),
    .rx_data     (rx_data),
    .rx_pop      (rx_pop),
    .rx_empty    (rx_empty),
    .irq_en      (irq_en),
    .IRQ_SPI     (IRQ_SPI),
    .rx_ovf      (rx_ovf),
    .busy        (busy),
    .SCK         (SCK),
    .MOSI        (MOSI),
    .MISO        (MISO),
    .SS          (SS)
  );

  // Monitors: cycle count, overflow pulses, finished words, SCK rise spacing.
  int cyc = 0, ovf_cnt = 0, done_cnt = 0, sck_rises = 0, sck_period = 0, last_rise = 0;
  always @(posedge clk_cpu) begin
    cyc++;
    if (rx_ovf === 1'b1) ovf_cnt++;
  end
  always @(negedge busy) done_cnt++;
  always @(posedge SCK) begin
    sck_rises++;
    sck_period = cyc - last_rise;
    last_rise  = cyc;
  end

  // Slave model: frame k (1-based count of SS falls) sends slave_a[k%64], records got_a[k%64].
  logic [31:0] slave_a [64];
  logic [31:0] got_a   [64];
  int          gap_a   [64];
  int          xfer_cnt = 0, s_pos = 0, s_n = 8, ss_hi_t = 0;
  logic [31:0] s_tx = '0, s_rx = '0;
  logic        ss_prev = 1'b0, sck_prev = 1'b0;

  function automatic logic sbit(input logic [31:0] w, input int p, input int n, input logic lsb);
    return lsb ? w[p] : w[n-1-p];
  endfunction

  always @(SCK or ss_low) begin
    if (ss_low === 1'b1 && ss_prev !== 1'b1) begin
      xfer_cnt++;
      gap_a[xfer_cnt % 64] = cyc - ss_hi_t;
      s_tx  = slave_a[xfer_cnt % 64];
      s_rx  = '0;
      s_pos = 0;
      s_n   = 8 * (int'(ctrl_len) + 1);
      if (!ctrl_cpha) slave_miso = sbit(s_tx, 0, s_n, ctrl_lsb);
    end else if (ss_low !== 1'b1 && ss_prev === 1'b1) begin
      got_a[xfer_cnt % 64] = s_rx;
      ss_hi_t = cyc;
    end else if (ss_low === 1'b1 && SCK !== sck_prev) begin
      if ((SCK != ctrl_cpol) ^ ctrl_cpha) begin
        if (s_pos < s_n) s_rx[ctrl_lsb ? s_pos : s_n - 1 - s_pos] = MOSI;
        if (ctrl_cpha) s_pos++;
      end else begin
        if (!ctrl_cpha) s_pos++;
        if (s_pos < s_n) slave_miso = sbit(s_tx, s_pos, s_n, ctrl_lsb);
      end
    end
    ss_prev  = ss_low;
    sck_prev = SCK;
  end

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wmask(input logic [1:0] len);
    return (len == 2'd3) ? 32'hFFFF_FFFF : ((32'h1 << (8 * (int'(len) + 1))) - 32'h1);
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_cpu);
  endtask

  task automatic push(input logic [31:0] w);
    tx_data = w;
    tx_push = 1'b1;
    @(negedge clk_cpu);
    tx_push = 1'b0;
  endtask

  task automatic pop();
    rx_pop = 1'b1;
    @(negedge clk_cpu);
    rx_pop = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget);
    int base;
    int t;
    base = done_cnt;
    t    = 0;
    while (done_cnt < base + n && t < budget) begin
      @(negedge clk_cpu);
      t++;
    end
    chk1("word_timeout", done_cnt >= base + n, 1'b1);
  endtask

  task automatic wait_bit(input int b, input int budget);
    int t;
    t = 0;
    while (!(ss_low === 1'b1 && s_pos == b) && t < budget) begin
      @(negedge clk_cpu);
      t++;
    end
    chk1("bit_timeout", t < budget, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          r0, nx, x0, o0;
    logic [31:0] tw, sw, ta, tb, sb;
    logic [31:0] tw_a [5];
    logic [31:0] sw_a [5];

    rst = 1'b0; spi_bitrate = 16'd2; ctrl_en = 1'b0; ctrl_cpol = 1'b0; ctrl_cpha = 1'b0;
    ctrl_lsb = 1'b0; ctrl_len = 2'd0; ctrl_ss_sel = 2'd0; tx_data = '0; tx_push = 1'b0;
    rx_pop = 1'b0; irq_en = 1'b1;
    for (int i = 0; i < 64; i++) slave_a[i] = '0;
    cycles(3);

    // Reset values
    chk1("rst_sck", SCK, 1'b0);
    chk1("rst_mosi", MOSI, 1'b0);
    chk("rst_ss", 32'(SS), 32'hF);
    chk1("rst_irq", IRQ_SPI, 1'b0);
    chk1("rst_ovf", rx_ovf, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_txfull", tx_full, 1'b0);
    chk1("rst_rxempty", rx_empty, 1'b1);
    chk("rst_rxdata", rx_data, 32'h0);
    rst = 1'b1;
    cycles(2);

    // Mode 0 loopback, 8-bit MSB-first
    loopback = 1'b1;
    ctrl_en  = 1'b1;
    r0 = sck_rises;
    nx = xfer_cnt + 1;
    push(32'hA5);
    wait_words(1, 400);
    chk("t1_pulses", r0 + 8, sck_rises);
    chk("t1_period", sck_period, 4);
    chk("t1_mosi_bits", got_a[nx % 64], 32'hA5);
    chk("t1_rx", rx_data, 32'h0000_00A5);
    chk1("t1_irq", IRQ_SPI, 1'b1);
    chk1("t1_sck_idle", SCK, 1'b0);
    pop();
    chk1("t1_rxempty", rx_empty, 1'b1);
    chk1("t1_irq_off", IRQ_SPI, 1'b0);

    // Modes 1-3, 32-bit LSB-first against the slave
    loopback = 1'b0;
    ctrl_len = 2'd3;
    ctrl_lsb = 1'b1;
    for (int m = 1; m <= 3; m++) begin
      ctrl_cpol = m[1];
      ctrl_cpha = m[0];
      @(negedge clk_cpu);
      nx = xfer_cnt + 1;
      slave_a[nx % 64] = 32'hCAFE_BABE;
      push(32'h1234_5678);
      wait_words(1, 1000);
      chk("t2_slave_got", got_a[nx % 64], 32'h1234_5678);
      chk("t2_rx", rx_data, 32'hCAFE_BABE);
      chk1("t2_sck_idle", SCK, ctrl_cpol);
      pop();
    end

    // Randomized mode/order/length/divisor
    for (int i = 0; i < 8; i++) begin
      ctrl_cpol   = 1'($urandom_range(0, 1));
      ctrl_cpha   = 1'($urandom_range(0, 1));
      ctrl_lsb    = 1'($urandom_range(0, 1));
      ctrl_len    = 2'($urandom_range(0, 3));
      spi_bitrate = 16'($urandom_range(0, 3));
      ctrl_ss_sel = 2'($urandom_range(0, 3));
      tw = $urandom;
      sw = $urandom;
      @(negedge clk_cpu);
      nx = xfer_cnt + 1;
      slave_a[nx % 64] = sw;
      push(tw);
      wait_words(1, 2000);
      chk("rnd_slave_got", got_a[nx % 64], tw & wmask(ctrl_len));
      chk("rnd_rx", rx_data, sw & wmask(ctrl_len));
      chk1("rnd_sck_idle", SCK, ctrl_cpol);
      pop();
    end

    // Fill TX while disabled, then run back-to-back
    ctrl_en = 1'b0; ctrl_cpol = 1'b0; ctrl_cpha = 1'b0; ctrl_lsb = 1'b0; ctrl_len = 2'd0;
    spi_bitrate = 16'd2; ctrl_ss_sel = 2'd0;
    @(negedge clk_cpu);
    x0 = xfer_cnt;
    for (int k = 0; k < 5; k++) begin
      tw_a[k] = $urandom;
      sw_a[k] = $urandom;
      slave_a[(x0 + 1 + k) % 64] = sw_a[k];
      if (k == 3) chk1("t3_not_full", tx_full, 1'b0);
      push(tw_a[k]);
      if (k == 3) chk1("t3_full", tx_full, 1'b1);
    end
    chk1("t3_still_full", tx_full, 1'b1);
    ctrl_en = 1'b1;
    wait_words(4, 2000);
    cycles(30);
    chk("t3_count", xfer_cnt - x0, 4);
    chk1("t3_idle", busy, 1'b0);
    for (int k = 0; k < 4; k++) chk("t3_slave_got", got_a[(x0 + 1 + k) % 64], tw_a[k] & 32'hFF);
    for (int k = 1; k < 4; k++) chk1("t3_ss_gap", gap_a[(x0 + 1 + k) % 64] >= 3, 1'b1);

    // Fifth word overflows the RX FIFO
    o0 = ovf_cnt;
    nx = xfer_cnt + 1;
    slave_a[nx % 64] = $urandom;
    push($urandom);
    wait_words(1, 500);
    cycles(2);
    chk("t4_ovf_pulses", ovf_cnt - o0, 1);
    chk("t4_head", rx_data, sw_a[0] & 32'hFF);
    for (int k = 0; k < 4; k++) begin
      chk("t4_drain", rx_data, sw_a[k] & 32'hFF);
      pop();
    end
    chk1("t4_empty", rx_empty, 1'b1);

    // Abort during bit 3 of a 16-bit word
    ctrl_en = 1'b0; ctrl_len = 2'd1; spi_bitrate = 16'd3; ctrl_ss_sel = 2'd1;
    @(negedge clk_cpu);
    ta = $urandom; tb = $urandom; sb = $urandom;
    nx = xfer_cnt + 1;
    slave_a[nx % 64] = $urandom;
    slave_a[(nx + 1) % 64] = sb;
    push(ta);
    push(tb);
    ctrl_en = 1'b1;
    wait_bit(3, 500);
    ctrl_en = 1'b0;
    @(negedge clk_cpu);
    chk("t5_ss", 32'(SS), 32'hF);
    chk1("t5_sck", SCK, 1'b0);
    chk1("t5_busy", busy, 1'b0);
    cycles(20);
    chk1("t5_no_rx", rx_empty, 1'b1);
    ctrl_en = 1'b1;
    wait_words(1, 1000);
    chk("t5_next_got", got_a[(nx + 1) % 64], tb & 32'hFFFF);
    chk("t5_next_rx", rx_data, sb & 32'hFFFF);
    pop();

    // Divisor 0, slave 2, then reset mid-word
    ctrl_en = 1'b0; ctrl_len = 2'd3; spi_bitrate = 16'd0; ctrl_ss_sel = 2'd2;
    @(negedge clk_cpu);
    push($urandom);
    push($urandom);
    ctrl_en = 1'b1;
    wait_bit(5, 200);
    chk("t6_ss_sel", 32'(SS), 32'hB);
    chk("t6_period", sck_period, 2);
    rst = 1'b0;
    #1;
    chk("t6_rst_ss", 32'(SS), 32'hF);
    chk1("t6_rst_sck", SCK, 1'b0);
    chk1("t6_rst_mosi", MOSI, 1'b0);
    chk1("t6_rst_busy", busy, 1'b0);
    chk1("t6_rst_irq", IRQ_SPI, 1'b0);
    @(negedge clk_cpu);
    rst = 1'b1;
    cycles(10);
    chk1("t6_tx_flushed", busy, 1'b0);
    chk1("t6_rx_empty", rx_empty, 1'b1);
    chk1("t6_tx_not_full", tx_full, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
